// File: rtl/sample_rate_divider_pkg.sv
// rtl/sample_rate_divider_pkg.sv - shared divider width, reset value and FSM state encoding
package sample_rate_divider_pkg;

  localparam int SAMPLE_DIV_W   = 24;
  localparam int SAMPLE_DIV_RST = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/sample_rate_divider.sv
// rtl/sample_rate_divider.sv - shadowed (D+1) sample-enable divider; SAMPLE_DIV_CLKOUT_EN adds a square-wave probe output
module sample_rate_divider
  import sample_rate_divider_pkg::*;
#(
  parameter int DIV_W   = SAMPLE_DIV_W,
  parameter int DIV_RST = SAMPLE_DIV_RST
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clk_locked,
  input  logic             run,
  input  logic             div_wr,
  input  logic [DIV_W-1:0] div_data,
  output logic             sample_ce,
  output logic             div_pending,
  output logic [DIV_W-1:0] div_active,
  output logic             sample_clk_o
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_div_active;
  logic [DIV_W-1:0] w_active_nxt;
  logic [DIV_W-1:0] r_pend_val;
  logic [DIV_W-1:0] w_pend_val_nxt;
  logic [DIV_W-1:0] w_next_div;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_ce;
  logic             w_ce_nxt;
  logic             w_load;
  logic             w_go;

  assign w_go = run & clk_locked;

  // A write landing on a load cycle beats any older pending value.
  assign w_next_div = div_wr ? div_data : (r_pending ? r_pend_val : r_div_active);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_active_nxt   = r_div_active;
    w_pend_val_nxt = r_pend_val;
    w_pending_nxt  = r_pending;
    w_ce_nxt       = 1'b0;
    w_load         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_load = 1'b1;
        if (w_go) begin
          w_state_nxt = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (!w_go) begin
          w_load      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_load   = 1'b1;
          w_ce_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - DIV_W'(1);
          if (div_wr) begin
            w_pend_val_nxt = div_data;
            w_pending_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_load) begin
      w_cnt_nxt     = w_next_div;
      w_active_nxt  = w_next_div;
      w_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt        <= DIV_W'(DIV_RST);
      r_div_active <= DIV_W'(DIV_RST);
      r_pend_val   <= '0;
      r_pending    <= 1'b0;
      r_ce         <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_div_active <= w_active_nxt;
      r_pend_val   <= w_pend_val_nxt;
      r_pending    <= w_pending_nxt;
      r_ce         <= w_ce_nxt;
    end
  end

  assign sample_ce   = r_ce;
  assign div_pending = r_pending;
  assign div_active  = r_div_active;

`ifdef SAMPLE_DIV_CLKOUT_EN
  logic r_clk_o;

  // Flips together with each strobe so the probe sees a 50% duty wave at half the strobe rate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_o <= 1'b0;
    end else if (r_state == ST_IDLE || !w_go) begin
      r_clk_o <= 1'b0;
    end else if (w_ce_nxt) begin
      r_clk_o <= ~r_clk_o;
    end
  end

  assign sample_clk_o = r_clk_o;
`else
  assign sample_clk_o = 1'b0;
`endif

endmodule
